// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // Number of byte-lane select bits in a byte address for a given data width.
  function automatic int unsigned lane_bits(int unsigned width);
    return $clog2(width / 8);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: merges a byte into a word and extracts/extends one lane.
// Only built when LSU_BYTE_EN is defined.
`ifdef LSU_BYTE_EN
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]              word,
  input  logic [lane_bits(WIDTH)-1:0]   lane,
  input  logic [7:0]                    lane_byte,
  input  logic                          is_signed,
  output logic [WIDTH-1:0]              merged,
  output logic [WIDTH-1:0]              extended
);

  localparam int unsigned LANE_BITS = lane_bits(WIDTH);

  logic [7:0] picked;

  // Replace the selected lane and pick the same lane out for extension.
  always_comb begin
    merged = word;
    picked = 8'h00;
    for (int i = 0; i < int'(WIDTH / 8); i++) begin
      if (lane == i[LANE_BITS-1:0]) begin
        merged[i*8 +: 8] = lane_byte;
        picked           = word[i*8 +: 8];
      end
    end
    extended = {{(WIDTH - 8){is_signed & picked[7]}}, picked};
  end

endmodule
`endif

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide data memory.
// Define LSU_BYTE_EN to build byte loads/stores (read-modify-write merge).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data
);

  localparam int unsigned LANE_BITS = lane_bits(WIDTH);

  lsu_state_e       state_q, state_d;
  logic             we_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic             req_is_word;
  logic             misaligned;
  logic             byte_op_q;
  logic [WIDTH-1:0] load_value;

`ifdef LSU_BYTE_EN
  logic                 size_q;
  logic                 signed_q;
  logic [LANE_BITS-1:0] lane_q;
  logic [WIDTH-1:0]     lane_word;
  logic [WIDTH-1:0]     lane_merged;
  logic [WIDTH-1:0]     lane_extended;

  assign req_is_word = (req_size == SIZE_WORD);
  assign byte_op_q   = (size_q == SIZE_BYTE);
  // Extract from the live read in ACCESS; merge into the captured word in MERGE.
  assign lane_word   = (state_q == MERGE) ? data_q : mem_read_data;
  assign load_value  = byte_op_q ? lane_extended : mem_read_data;

  lsu_byte_lane #(
    .WIDTH (WIDTH)
  ) u_byte_lane (
    .word      (lane_word),
    .lane      (lane_q),
    .lane_byte (wdata_q[7:0]),
    .is_signed (signed_q),
    .merged    (lane_merged),
    .extended  (lane_extended)
  );
`else
  logic unused_cfg;

  assign unused_cfg  = ^{req_size, req_signed};
  assign req_is_word = 1'b1;
  assign byte_op_q   = 1'b0;
  assign load_value  = mem_read_data;
`endif

  assign misaligned = req_is_word && (req_addr[LANE_BITS-1:0] != '0);

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = misaligned ? RESP : ACCESS;
`ifdef LSU_BYTE_EN
      ACCESS:  state_d = (we_q && byte_op_q) ? MERGE : RESP;
      MERGE:   state_d = RESP;
`else
      ACCESS:  state_d = RESP;
`endif
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from the current state.
  always_comb begin
    req_ready      = (state_q == IDLE);
    resp_valid     = (state_q == RESP);
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    case (state_q)
      ACCESS: begin
        if (we_q && !byte_op_q) begin
          mem_write_en   = 1'b1;
          mem_write_data = wdata_q;
        end
      end
`ifdef LSU_BYTE_EN
      MERGE: begin
        mem_write_en   = 1'b1;
        mem_write_data = lane_merged;
      end
`endif
      default: ;
    endcase
  end

  // Request latch, load capture and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
`ifdef LSU_BYTE_EN
      size_q     <= SIZE_WORD;
      signed_q   <= 1'b0;
      lane_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            wdata_q <= req_wdata;
            data_q  <= '0;
            err_q   <= misaligned;
            // A misaligned request never touches memory, so mem_addr keeps its old value.
            if (!misaligned) mem_addr_q <= {{LANE_BITS{1'b0}}, req_addr[WIDTH-1:LANE_BITS]};
`ifdef LSU_BYTE_EN
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[LANE_BITS-1:0];
`endif
          end
        end
        ACCESS: begin
          if (!we_q)          data_q <= load_value;
          else if (byte_op_q) data_q <= mem_read_data;
        end
        MERGE:   data_q <= '0;
        RESP:    if (resp_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign resp_data = data_q;
  assign resp_err  = err_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit that sits directly upstream of the word-wide data memory. It accepts load/store requests from the execute stage over a valid/ready handshake and translates byte addresses into word indices. Byte stores are performed as read-modify-write on the word array, and load results are returned over a second valid/ready handshake. Misaligned word accesses are flagged and never reach the memory.

## Interface
- WIDTH, 16: data and address width; legal values 16 or 32.
- LANE_BITS, $clog2(WIDTH/8): byte-lane select bits in a byte address; derived, not overridden.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  1  0 = word, 1 = byte.
- req_signed  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data; byte store uses bits [7:0].
- resp_valid  out  1  response present; held until taken.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  misaligned word access.
- mem_write_en  out  1  write strobe to data memory.
- mem_addr  out  WIDTH  word index, {LANE_BITS zeros, addr[WIDTH-1:LANE_BITS]}.
- mem_write_data  out  WIDTH  word written.
- mem_read_data  in  WIDTH  combinational read of mem_addr.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/signed/addr/wdata, then go to ACCESS.
  - A word request with addr[LANE_BITS-1:0]≠0 sets err and goes straight to RESP with no memory access.
- ACCESS drives mem_addr from the latched address. Action by request type:
  - Load: capture mem_read_data. A byte load extracts lane addr[LANE_BITS-1:0] (lane 0 = bits [7:0]) and extends it per req_signed. Then go to RESP.
  - Word store: mem_write_en=1, mem_write_data=wdata, then go to RESP.
  - Byte store: capture mem_read_data, then go to MERGE.
- MERGE: mem_write_en=1. mem_write_data is the captured word with the selected lane replaced by wdata[7:0]; other lanes are unchanged. Then go to RESP.
- RESP:
  - resp_valid=1, with resp_data and resp_err stable.
  - When resp_ready=1, go to IDLE and clear err.
- mem_write_en is 0 in every other state. mem_addr holds its last value outside ACCESS/MERGE.
- req_valid outside IDLE is ignored; the requester must hold the request until it sees req_ready.

## Timing
- Acceptance at edge T (IDLE, req_valid). Earliest response timing:
  - Word load/store: ACCESS in cycle T+1, resp_valid from T+2.
  - Byte store: write in MERGE at T+2, resp_valid from T+3.
  - Misaligned: resp_valid from T+1.
- RESP→IDLE on the edge where resp_ready=1. The next request is accepted no earlier than the following edge, so steady-state throughput is one op per 3 cycles (4 for byte stores).
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_write_en=0, mem_addr=0, mem_write_data=0.
- Reset during ACCESS or MERGE aborts the operation immediately:
  - mem_write_en drops asynchronously.
  - No partial write occurs after reset deasserts.
  - No response is produced.

## Configuration
- LSU_BYTE_EN defined: byte loads/stores behave as above, including MERGE and lane extract/extend.
- LSU_BYTE_EN undefined:
  - req_size and req_signed are ignored and every request is a word access.
  - MERGE state and lane logic are not built.
  - The misalignment check still applies.

## Structure
- Package lsu_pkg holds:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, MERGE=2'd2, RESP=2'd3.
  - Size encoding: SIZE_WORD=1'b0, SIZE_BYTE=1'b1.
  - The LANE_BITS derivation function.
- One combinational sub-module, lsu_byte_lane (present only under LSU_BYTE_EN):
  - Inputs: word, lane, byte, signed.
  - Outputs: merged word and extended byte.

## Test plan
- Word store 0xBEEF @0x0010, then word load @0x0010 → mem_addr=0x0008 with one mem_write_en pulse; load resp_data=0xBEEF, resp_valid at T+2.
- Memory word 0x1234 @ index 4; byte store 0xAB @0x0009 → single write of 0xAB34; resp at T+3; byte load @0x0008 signed → 0x0034.
- Memory word 0x80FF; byte load lane 1 signed → 0xFF80; unsigned → 0x0080.
- Word load @0x0003 → resp_err=1, resp_data=0, no mem_write_en, resp_valid at T+1.
- Hold resp_ready=0 for 5 cycles with a new req_valid pending → resp stable, req_ready=0; the new request is accepted only on the edge after resp_ready=1.
- Assert reset in MERGE of a byte store → mem_write_en=0 immediately, memory unchanged, req_ready=1, resp_valid=0.
